// File: rtl/quad_updown_decoder_if.sv
// Bundle of the quadrature decoder's control, phase and status signals.
// master drives the phases and controls; slave is the decoder.
interface quad_updown_decoder_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             a_in;
   logic             b_in;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_err;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             step;
   logic             wrap;
   logic             err;
   logic             err_sticky;

   modport master (
      output en, a_in, b_in, load, load_val, clr_err,
      input  count, dir, step, wrap, err, err_sticky
   );

   modport slave (
      input  en, a_in, b_in, load, load_val, clr_err,
      output count, dir, step, wrap, err, err_sticky
   );
endinterface

// File: rtl/quad_updown_decoder.sv
// Quadrature step receiver: synchronizes A/B and keeps a wrapping up/down position counter.
// Define QDEC_GLITCH_FILTER_EN to add a 3-sample glitch filter after the synchronizers.
module quad_updown_decoder #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                 clk,
   input logic                 rst,
   quad_updown_decoder_if.slave bus
);
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int unsigned PrimeLen = SYNC_STAGES + 3;
`else
   localparam int unsigned PrimeLen = SYNC_STAGES + 1;
`endif
   localparam int unsigned PrimeW = $clog2(PrimeLen + 1);

   logic [1:0]        sync_q [SYNC_STAGES];
   logic [1:0]        sync_ph;
   logic [1:0]        cur;
   logic [1:0]        prev_q;
   logic [1:0]        delta;
   logic [PrimeW-1:0] prime_q;
   logic              priming;
   logic [WIDTH-1:0]  count_q, count_d;
   logic              dir_q, dir_d;
   logic              step_q, step_d;
   logic              wrap_q, wrap_d;
   logic              err_q, err_d;
   logic              sticky_q, sticky_d;

   // Map the Gray-coded phase onto a binary position so the step direction is a subtraction.
   function automatic logic [1:0] gray_pos(input logic [1:0] p);
      return {p[1], p[1] ^ p[0]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
      end else begin
         sync_q[0] <= {bus.a_in, bus.b_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_ph = sync_q[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
   logic [1:0] samp1_q, samp2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         samp1_q <= 2'b00;
         samp2_q <= 2'b00;
      end else begin
         samp1_q <= sync_ph;
         samp2_q <= samp1_q;
      end
   end

   // prev_q already holds the last accepted value, so it doubles as the filter's hold register.
   assign cur = (sync_ph == samp1_q && sync_ph == samp2_q) ? sync_ph : prev_q;
`else
   assign cur = sync_ph;
`endif

   assign priming = (prime_q != PrimeW'(PrimeLen));
   assign delta   = gray_pos(cur) - gray_pos(prev_q);

   always_comb begin
      count_d  = count_q;
      dir_d    = dir_q;
      step_d   = 1'b0;
      wrap_d   = 1'b0;
      err_d    = 1'b0;
      sticky_d = sticky_q & ~bus.clr_err;
      if (!priming) begin
         if (delta == 2'd2) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
         end else if (bus.en && delta == 2'd1) begin
            count_d = count_q + 1'b1;
            dir_d   = 1'b1;
            step_d  = 1'b1;
            wrap_d  = (count_q == {WIDTH{1'b1}});
         end else if (bus.en && delta == 2'd3) begin
            count_d = count_q - 1'b1;
            dir_d   = 1'b0;
            step_d  = 1'b1;
            wrap_d  = (count_q == '0);
         end
      end
      if (bus.load) begin
         count_d = bus.load_val;
         dir_d   = dir_q;
         step_d  = 1'b0;
         wrap_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= 2'b00;
         prime_q  <= '0;
         count_q  <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         prev_q   <= cur;
         if (priming) prime_q <= prime_q + 1'b1;
         count_q  <= count_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.count      = count_q;
   assign bus.dir        = dir_q;
   assign bus.step       = step_q;
   assign bus.wrap       = wrap_q;
   assign bus.err        = err_q;
   assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed bench for quad_updown_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_quad_updown_decoder;
   localparam int unsigned Width = 4;
   localparam int unsigned Sync  = 2;
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int Lat  = Sync + 2;
   localparam int Hold = 3;
`else
   localparam int Lat  = Sync;
   localparam int Hold = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   quad_updown_decoder_if #(.WIDTH(Width)) bus ();

   quad_updown_decoder #(.WIDTH(Width), .SYNC_STAGES(Sync)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_phase(input logic [1:0] ph);
      bus.a_in = ph[1];
      bus.b_in = ph[0];
   endtask

   // Apply one phase change, optionally with load/clr_err on the edge where it is decoded.
   task automatic move(input logic [1:0] ph, input logic ld, input logic clr,
                       input logic [3:0] e_count, input logic e_step, input logic e_dir,
                       input logic e_wrap, input logic e_err, input string tag);
      set_phase(ph);
      repeat (Lat) tick();
      bus.load    = ld;
      bus.clr_err = clr;
      tick();
      bus.load    = 1'b0;
      bus.clr_err = 1'b0;
      check({tag, ".count"}, 32'(bus.count), 32'(e_count));
      check({tag, ".step"},  32'(bus.step),  32'(e_step));
      check({tag, ".dir"},   32'(bus.dir),   32'(e_dir));
      check({tag, ".wrap"},  32'(bus.wrap),  32'(e_wrap));
      check({tag, ".err"},   32'(bus.err),   32'(e_err));
      tick();
      check({tag, ".pulse_end"}, 32'({bus.step, bus.wrap, bus.err}), 32'(0));
   endtask

   initial begin
      logic [1:0] up_seq [4];
      int         pos;
      int         k;
      up_seq[0] = 2'b00;
      up_seq[1] = 2'b01;
      up_seq[2] = 2'b11;
      up_seq[3] = 2'b10;

      rst          = 1'b1;
      bus.en       = 1'b1;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.clr_err  = 1'b0;
      set_phase(2'b11);
      repeat (3) tick();
      check("reset.count", 32'(bus.count), 32'(0));
      check("reset.dir", 32'(bus.dir), 32'(0));
      check("reset.sticky", 32'(bus.err_sticky), 32'(0));

      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("prime.step_err", 32'({bus.step, bus.err}), 32'(0));
      end
      check("prime.count", 32'(bus.count), 32'(0));
      check("prime.sticky", 32'(bus.err_sticky), 32'(0));

      // 16 up transitions starting from phase 11, back-to-back at the fastest accepted rate
      pos = 2;
      for (int t = 0; t <= 16 * Hold + Lat; t++) begin
         if (t < 16 * Hold && (t % Hold) == 0) begin
            pos = (pos + 1) % 4;
            set_phase(up_seq[pos]);
         end
         tick();
         if (t >= Lat && ((t - Lat) % Hold) == 0 && (t - Lat) / Hold < 16) begin
            k = (t - Lat) / Hold;
            check("up.count", 32'(bus.count), 32'((k + 1) % 16));
            check("up.step", 32'(bus.step), 32'(1));
            check("up.dir", 32'(bus.dir), 32'(1));
            check("up.wrap", 32'(bus.wrap), 32'(k == 15));
         end else begin
            check("up.idle", 32'({bus.step, bus.wrap, bus.err}), 32'(0));
            if (t < Lat) check("up.latency", 32'(bus.count), 32'(0));
         end
      end

      bus.load_val = 4'd2;
      bus.load     = 1'b1;
      tick();
      bus.load = 1'b0;
      check("load2.count", 32'(bus.count), 32'(2));
      check("load2.step", 32'(bus.step), 32'(0));

      move(2'b01, 1'b0, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, "down1");
      move(2'b00, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, "down2");
      move(2'b10, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, "down3");
      move(2'b00, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, "upwrap");

      move(2'b11, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, "jump1");
      check("jump1.sticky", 32'(bus.err_sticky), 32'(1));
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      check("clr.sticky", 32'(bus.err_sticky), 32'(0));
      move(2'b00, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, "jump2");
      check("jump2.sticky_set_wins", 32'(bus.err_sticky), 32'(1));
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      check("clr2.sticky", 32'(bus.err_sticky), 32'(0));

      bus.en = 1'b0;
      move(2'b01, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, "en_off");
      bus.en = 1'b1;
      move(2'b11, 1'b0, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, "en_on");
      check("en_on.sticky", 32'(bus.err_sticky), 32'(0));

      bus.load_val = 4'd9;
      move(2'b10, 1'b1, 1'b0, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, "load_vs_step");
      check("load_vs_step.hold", 32'(bus.count), 32'(9));

`ifdef QDEC_GLITCH_FILTER_EN
      set_phase(2'b00);
      repeat (2) tick();
      set_phase(2'b10);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("glitch.step_err", 32'({bus.step, bus.err}), 32'(0));
      end
      check("glitch.count", 32'(bus.count), 32'(9));
`endif

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rerst.count", 32'(bus.count), 32'(0));
      check("rerst.dir", 32'(bus.dir), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/quad_updown_decoder.md
# quad_updown_decoder

Synchronous receiver for a two-phase quadrature step interface. It recovers up/down count events from phase inputs a_in/b_in, which may be asynchronous, and maintains a WIDTH-bit wrapping position counter in the clk domain. It is the receive-side counterpart to the team's up/down counter blocks: a phase generator or mechanical encoder drives it, and it produces a clean synchronous count, direction, and per-step strobes for downstream logic.

## Interface
- WIDTH, 4, position counter width (>=2)
- SYNC_STAGES, 2, synchronizer flops per phase input (>=2)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  count enable; when low, transitions are tracked but not counted
- a_in  input  1  phase A, asynchronous
- b_in  input  1  phase B, asynchronous
- load  input  1  synchronous load of load_val into count
- load_val  input  WIDTH  load value
- clr_err  input  1  clears err_sticky
- count  output  WIDTH  position counter
- dir  output  1  direction of last accepted step: 1 = up, 0 = down
- step  output  1  one-cycle pulse per accepted step
- wrap  output  1  one-cycle pulse when count wraps (max->0 up, 0->max down)
- err  output  1  one-cycle pulse on an illegal transition (both phases changed)
- err_sticky  output  1  set by err, held until clr_err or rst

## Operation
- The phase state is {A,B}, taken after synchronization. The up sequence is 00->01->11->10->00 (B leads A). The reverse sequence is down.
- Each cycle, the synchronized phase cur is compared with the registered prev. prev <= cur every cycle after priming.
- cur == prev: no event.
- A single-bit change in the up order, with en=1: count <= count+1, dir <= 1, step pulses.
- A single-bit change in the down order, with en=1: count <= count-1, dir <= 0, step pulses.
- A two-bit change: err pulses and err_sticky <= 1. count and dir are unchanged and step stays low. This applies regardless of en.
- en=0: prev still tracks cur. No count, step, dir, or wrap activity. err remains active.
- Arithmetic is modulo 2^WIDTH. Up from 2^WIDTH-1 gives 0 with a wrap pulse; down from 0 gives 2^WIDTH-1 with a wrap pulse.
- load=1: count <= load_val. Load takes priority over a simultaneous step, so step and wrap are suppressed that cycle. dir is unchanged, and err is still reported.
- clr_err and a simultaneous err in the same cycle: err_sticky ends at 1 (set wins).
- Priming: for SYNC_STAGES+1 cycles after rst deasserts, prev <= cur with no event detection. This prevents a spurious err or step when inputs are not 00 at reset.
- Reset (rst=1): synchronizers, prev, count, dir, step, wrap, err, and err_sticky are all cleared to 0. The priming counter restarts.
- rst asserted mid-operation takes effect on the next edge and discards any in-flight synchronizer contents.

## Timing
- A phase edge stable before rising edge N appears in count, dir, step, and wrap after edge N+SYNC_STAGES. With defaults, that is 2 cycles of latency.
- step, wrap, and err are high for exactly one cycle per event.
- Steps may arrive as often as one per cycle at the synchronized phase. Each counts individually.
- The count output is registered. There are no combinational paths from inputs to outputs.

## Configuration
- QDEC_GLITCH_FILTER_EN defined: a filter stage sits after the synchronizers.
  - A new phase value is accepted into cur only after 3 consecutive identical synchronized samples. Shorter pulses are discarded with no step and no err.
  - This adds 2 cycles of latency, giving edge N+SYNC_STAGES+2.
  - The priming length becomes SYNC_STAGES+3.
- QDEC_GLITCH_FILTER_EN undefined: no filter. cur is the synchronizer output directly.

## Test plan
- Reset with a_in=b_in=1 held, then release: after priming, count=0, step=0, err=0, err_sticky=0.
- Drive 4 full up cycles (16 transitions) from count=0: count returns to 0 and wrap pulses once. 16 step pulses occur with dir=1, and count=1 appears 2 cycles after the first edge.
- Load load_val=2, then drive 3 down transitions: count goes 1, 0, 15. wrap pulses on 0->15 and dir=0.
- Jump phase 00->11: err pulses once and err_sticky=1 with count unchanged. Pulse clr_err and err_sticky returns to 0. Repeat with clr_err coincident with the err event and err_sticky stays 1.
- Drive an up transition with en=0, then with en=1: the first leaves count unchanged, and the second increments by exactly 1 with no err.
- Pulse load with load_val=9 in the same cycle a step is detected: count=9 and no step pulse. With QDEC_GLITCH_FILTER_EN defined, a 2-cycle phase glitch produces no step and no err.
